// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: funct3 codes, FSM states,
// request classes and the acceptance-time request classifier.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_RMW_WR,
    S_STORE,
    S_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    CLS_OK,
    CLS_ILLEGAL,
    CLS_MISALIGNED,
    CLS_FAULT
  } lsu_class_e;

  // Only the highest-priority problem is reported: illegal > misaligned > fault.
  function automatic lsu_class_e lsu_classify(input logic        we,
                                              input logic [2:0]  funct3,
                                              input logic [31:0] addr,
                                              input logic [31:0] mem_bytes);
    logic illegal;
    logic misaligned;
    illegal    = we ? (funct3 >= 3'b011)
                    : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (illegal)                lsu_classify = CLS_ILLEGAL;
    else if (misaligned)        lsu_classify = CLS_MISALIGNED;
    else if (addr >= mem_bytes) lsu_classify = CLS_FAULT;
    else                        lsu_classify = CLS_OK;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response and memory-port bundle between the pipeline, the LSU and memory.
interface lsu_mem_initiator_if;
  // A request transfers on a rising edge where req_valid && req_ready; the
  // requester holds its fields stable while req_valid is high and not yet accepted.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
           resp_fault, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
           resp_fault, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extraction/extension and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] ld_word,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = ld_word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane[1] ? ld_word[31:16] : ld_word[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_word;
    endcase
  end

  // Untouched lanes keep the value just read from memory.
  always_comb begin
    st_word = st_old;
    case (funct3)
      F3_B:    st_word[{lane, 3'b000} +: 8]        = st_wdata[7:0];
      F3_H:    st_word[{lane[1], 4'b0000} +: 16]   = st_wdata[15:0];
      default: st_word = st_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: accepts one RV32I memory request at a time, classifies it,
// and performs the load, word store, or read-modify-write against a word memory.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  lsu_mem_initiator_if.master bus,
  output lsu_state_e         dbg_state
);

  lsu_state_e  state_q, state_d;
  lsu_class_e  cls_q, cls_in;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        accept;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign cls_in    = lsu_classify(bus.req_we, bus.req_funct3, bus.req_addr, 32'(MEM_BYTES));
  assign dbg_state = state_q;

  lsu_lane_align u_align (
    .funct3   (f3_q),
    .lane     (addr_q[1:0]),
    .ld_word  (bus.mem_rdata),
    .st_old   (bus.mem_rdata),
    .st_wdata (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Memory strobes and response flags decode straight from state, so reset
  // withdraws a pending write immediately.
  always_comb begin
    state_d             = state_q;
    bus.req_ready       = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = 32'd0;
    bus.mem_wdata       = 32'd0;
    bus.resp_valid      = 1'b0;
    bus.resp_misaligned = 1'b0;
    bus.resp_illegal    = 1'b0;
    bus.resp_fault      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (cls_in != CLS_OK)          state_d = S_RESP;
          else if (!bus.req_we)          state_d = S_LOAD;
          else if (bus.req_funct3 == F3_W) state_d = S_STORE;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        bus.mem_addr = {addr_q[31:2], 2'b00};
        state_d      = S_RESP;
      end
      S_RMW_RD: begin
        bus.mem_addr = {addr_q[31:2], 2'b00};
        state_d      = S_RMW_WR;
      end
      S_RMW_WR: begin
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merge_q;
        state_d       = S_RESP;
      end
      S_STORE: begin
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = wdata_q;
        state_d       = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid      = 1'b1;
        bus.resp_misaligned = (cls_q == CLS_MISALIGNED);
        bus.resp_illegal    = (cls_q == CLS_ILLEGAL);
        bus.resp_fault      = (cls_q == CLS_FAULT);
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q   <= CLS_OK;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        cls_q   <= cls_in;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      case (state_q)
        S_LOAD:   rdata_q <= ld_data;
        S_RMW_RD: merge_q <= st_word;
        S_RESP:   rdata_q <= 32'd0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-array memory model, directed scenarios and
// randomized requests compared against the model.
module tb_lsu_mem_initiator;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_init = 1'b1;
  lsu_state_e dbg_state;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator #(.MEM_BYTES(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT
  logic [31:0] tb_mem [256];
  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hDEADBEEF;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  // Reference model: flat little-endian byte array
  logic [7:0] ref_mem [1024];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] obs_rdata, obs_we_addr;
  logic        obs_mis, obs_ill, obs_flt, obs_timeout;
  lsu_state_e  obs_we_state;
  int          obs_lat, obs_we_cnt, obs_addr_act;

  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // 0 ok, 1 illegal, 2 misaligned, 3 fault
  function automatic int ref_class(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1;
    if ((addr % ref_size(f3)) != 0) return 2;
    if (addr >= 32'd1024) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v, mask;
    int sz;
    sz = ref_size(f3);
    v = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] sh;
    for (int i = 0; i < ref_size(f3); i++) begin
      sh = wdata >> (8 * i);
      ref_mem[addr + i] = sh[7:0];
    end
  endtask

  // Issue one request and record what the DUT does until its response (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    obs_timeout = 1'b1; obs_lat = 0; obs_we_cnt = 0; obs_addr_act = 0;
    obs_rdata = 32'hx; obs_mis = 1'bx; obs_ill = 1'bx; obs_flt = 1'bx;
    obs_we_addr = 32'd0; obs_we_state = S_IDLE;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        obs_we_cnt++;
        obs_we_addr  = bus.mem_addr;
        obs_we_state = dbg_state;
      end
      if (bus.mem_addr != 32'd0) obs_addr_act++;
      if (bus.resp_valid) begin
        obs_lat = n; obs_timeout = 1'b0;
        obs_rdata = bus.resp_rdata; obs_mis = bus.resp_misaligned;
        obs_ill = bus.resp_illegal; obs_flt = bus.resp_fault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0 || bus.resp_misaligned !== 1'b0 || bus.resp_illegal !== 1'b0 || bus.resp_fault !== 1'b0) begin
      miscompares++; $display("FAIL reset_resp got v%b m%b i%b f%b exp all 0", bus.resp_valid, bus.resp_misaligned, bus.resp_illegal, bus.resp_fault); end
    vectors++; if (bus.resp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", bus.resp_rdata); end
    vectors++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      miscompares++; $display("FAIL reset_mem got we%b a%h d%h exp 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    vectors++; if (dbg_state !== S_IDLE) begin miscompares++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
  endtask

  task automatic test_directed_loads();
    logic [2:0]  f3s   [3] = '{F3_B, F3_BU, F3_HU};
    logic [31:0] addrs [3] = '{32'h3, 32'h3, 32'h2};
    logic [31:0] exps  [3] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD};
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, f3s[i], addrs[i], 32'd0);
      vectors++; if (obs_timeout !== 1'b0 || obs_lat != 2) begin miscompares++; $display("FAIL load%0d_latency got %0d exp 2", i, obs_lat); end
      vectors++; if (obs_rdata !== exps[i]) begin miscompares++; $display("FAIL load%0d_rdata got %h exp %h", i, obs_rdata, exps[i]); end
      vectors++; if (obs_rdata !== ref_load(f3s[i], addrs[i])) begin miscompares++; $display("FAIL load%0d_model got %h exp %h", i, obs_rdata, ref_load(f3s[i], addrs[i])); end
    end
  endtask

  task automatic test_sw_lw();
    do_req(1'b1, F3_W, 32'h10, 32'h12345678);
    ref_store(F3_W, 32'h10, 32'h12345678);
    vectors++; if (obs_timeout !== 1'b0 || obs_lat != 2) begin miscompares++; $display("FAIL sw_latency got %0d exp 2", obs_lat); end
    vectors++; if (obs_we_cnt != 1 || obs_we_addr !== 32'h10) begin miscompares++; $display("FAIL sw_write got cnt %0d addr %h exp 1 @00000010", obs_we_cnt, obs_we_addr); end
    vectors++; if (obs_rdata !== 32'd0) begin miscompares++; $display("FAIL sw_rdata got %h exp 0", obs_rdata); end
    do_req(1'b0, F3_W, 32'h10, 32'd0);
    vectors++; if (obs_rdata !== 32'h12345678) begin miscompares++; $display("FAIL lw_readback got %h exp 12345678", obs_rdata); end
  endtask

  task automatic test_sb_rmw();
    do_req(1'b1, F3_B, 32'h11, 32'h000000AA);
    ref_store(F3_B, 32'h11, 32'h000000AA);
    vectors++; if (obs_timeout !== 1'b0 || obs_lat != 3) begin miscompares++; $display("FAIL sb_latency got %0d exp 3", obs_lat); end
    vectors++; if (obs_we_cnt != 1 || obs_we_state !== S_RMW_WR) begin miscompares++; $display("FAIL sb_write got cnt %0d state %0d exp 1 in RMW_WR", obs_we_cnt, obs_we_state); end
    vectors++; if (tb_mem[4] !== ref_load(F3_W, 32'h10)) begin miscompares++; $display("FAIL sb_word got %h exp %h", tb_mem[4], ref_load(F3_W, 32'h10)); end
    do_req(1'b0, F3_W, 32'h10, 32'd0);
    vectors++; if (obs_rdata !== ref_load(F3_W, 32'h10)) begin miscompares++; $display("FAIL sb_readback got %h exp %h", obs_rdata, ref_load(F3_W, 32'h10)); end
  endtask

  task automatic test_faults();
    do_req(1'b0, F3_W, 32'h6, 32'd0);
    vectors++; if ({obs_ill, obs_mis, obs_flt} !== 3'b010 || obs_we_cnt != 0 || obs_lat != 1) begin
      miscompares++; $display("FAIL lw_misaligned got ilmf %b%b%b we %0d lat %0d exp 010/0/1", obs_ill, obs_mis, obs_flt, obs_we_cnt, obs_lat); end
    do_req(1'b1, F3_H, 32'h401, 32'hBEEF);
    vectors++; if ({obs_ill, obs_mis, obs_flt} !== 3'b010 || obs_we_cnt != 0) begin
      miscompares++; $display("FAIL sh_misaligned_oob got ilmf %b%b%b we %0d exp 010/0", obs_ill, obs_mis, obs_flt, obs_we_cnt); end
    do_req(1'b0, F3_W, 32'h400, 32'd0);
    vectors++; if ({obs_ill, obs_mis, obs_flt} !== 3'b001 || obs_lat != 1 || obs_rdata !== 32'd0) begin
      miscompares++; $display("FAIL lw_fault got ilmf %b%b%b lat %0d rdata %h exp 001/1/0", obs_ill, obs_mis, obs_flt, obs_lat, obs_rdata); end
  endtask

  task automatic test_illegal();
    do_req(1'b0, 3'b011, 32'h10, 32'd0);
    vectors++; if ({obs_ill, obs_mis, obs_flt} !== 3'b100 || obs_rdata !== 32'd0) begin
      miscompares++; $display("FAIL illegal_flags got ilmf %b%b%b rdata %h exp 100/0", obs_ill, obs_mis, obs_flt, obs_rdata); end
    vectors++; if (obs_we_cnt != 0 || obs_addr_act != 0) begin
      miscompares++; $display("FAIL illegal_mem got we %0d addr_cycles %0d exp 0/0", obs_we_cnt, obs_addr_act); end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, exp_rdata;
    int          cls, exp_lat, exp_we;
    for (int i = 0; i < 150; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1020, 1100)) : 32'($urandom_range(0, 255));
      wdata = $urandom;
      cls   = ref_class(we, f3, addr);
      exp_rdata = (cls == 0 && !we) ? ref_load(f3, addr) : 32'd0;
      exp_lat   = (cls != 0) ? 1 : (!we || f3 == F3_W) ? 2 : 3;
      exp_we    = (cls == 0 && we) ? 1 : 0;
      do_req(we, f3, addr, wdata);
      if (cls == 0 && we) ref_store(f3, addr, wdata);
      vectors++; if (obs_timeout !== 1'b0 || obs_lat != exp_lat) begin
        miscompares++; $display("FAIL rand%0d_latency got %0d exp %0d", i, obs_lat, exp_lat); end
      vectors++; if ({obs_ill, obs_mis, obs_flt} !== {cls == 1, cls == 2, cls == 3}) begin
        miscompares++; $display("FAIL rand%0d_flags got ilmf %b%b%b exp class %0d", i, obs_ill, obs_mis, obs_flt, cls); end
      vectors++; if (obs_rdata !== exp_rdata) begin
        miscompares++; $display("FAIL rand%0d_rdata got %h exp %h", i, obs_rdata, exp_rdata); end
      vectors++; if (obs_we_cnt != exp_we || (exp_we == 1 && obs_we_addr !== {addr[31:2], 2'b00})) begin
        miscompares++; $display("FAIL rand%0d_write got cnt %0d addr %h exp %0d", i, obs_we_cnt, obs_we_addr, exp_we); end
    end
    for (int w = 0; w < 256; w++) begin
      vectors++; if (tb_mem[w] !== ref_load(F3_W, 32'(w * 4))) begin
        miscompares++; $display("FAIL final_mem%0d got %h exp %h", w, tb_mem[w], ref_load(F3_W, 32'(w * 4))); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen_wr = 1'b0;
    bit seen_resp = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int n = 0; n < 4 && !seen_wr; n++) begin
      @(negedge clk);
      if (dbg_state == S_RMW_WR && bus.mem_we) seen_wr = 1'b1;
    end
    vectors++; if (!seen_wr) begin miscompares++; $display("FAIL mid_reach_rmw_wr got 0 exp 1"); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_we_drop got %b exp 0", bus.mem_we); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (bus.resp_valid) seen_resp = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen_resp) begin miscompares++; $display("FAIL mid_no_resp got 1 exp 0"); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b exp 1", bus.req_ready); end
    vectors++; if (tb_mem[8] !== ref_load(F3_W, 32'h20)) begin miscompares++; $display("FAIL mid_word got %h exp %h", tb_mem[8], ref_load(F3_W, 32'h20)); end
    do_req(1'b0, F3_W, 32'h20, 32'd0);
    vectors++; if (obs_timeout !== 1'b0 || obs_rdata !== ref_load(F3_W, 32'h20)) begin
      miscompares++; $display("FAIL mid_lw got %h exp %h", obs_rdata, ref_load(F3_W, 32'h20)); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(32'hDEADBEEF >> (8 * (i % 4)));
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    mem_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed_loads();
    test_sw_lw();
    test_sb_rmw();
    test_faults();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
